ex_muldiv: RTL

- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO with forwarded operands, and owns the architectural HI/LO registers.
- Raises `busy` so the hazard unit can stall the pipeline on MFHI/MFLO or a new mul/div.
- One clock, radix-2 (one bit per cycle) shift-add multiply and restoring divide.

---
 rtl/ex_muldiv.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit for the EX stage; owns architectural HI/LO.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            div0,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]      opb_q, opb_d;
    logic [XLEN-1:0]      rs_cap_q, rs_cap_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rs_neg_q, rs_neg_d;
    logic                 b_zero_q, b_zero_d;
    logic [XLEN-1:0]      hi_q, hi_d;
    logic [XLEN-1:0]      lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div0_q, div0_d;

    logic                 signed_op;
    logic                 rs_s, rt_s;
    logic [XLEN-1:0]      abs_rs, abs_rt;
    logic [XLEN:0]        mul_sum;
    logic [XLEN:0]        div_trial;
    logic [2*XLEN-1:0]    prod_fix;
    logic [XLEN-1:0]      quo_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]    fast_a, fast_b, fast_prod;
`endif

    // Operand magnitudes: signed ops iterate on |x| and fix the sign in FIX.
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        rs_s      = signed_op && rs_val[XLEN-1];
        rt_s      = signed_op && rt_val[XLEN-1];
        abs_rs    = rs_s ? -rs_val : rs_val;
        abs_rt    = rt_s ? -rt_val : rt_val;
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = rs_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
`ifdef MULDIV_FAST_MUL_EN
        fast_a    = signed_op ? {{XLEN{rs_val[XLEN-1]}}, rs_val} : {{XLEN{1'b0}}, rs_val};
        fast_b    = signed_op ? {{XLEN{rt_val[XLEN-1]}}, rt_val} : {{XLEN{1'b0}}, rt_val};
        fast_prod = fast_a * fast_b;
`endif
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        rs_cap_d = rs_cap_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rs_neg_d = rs_neg_q;
        b_zero_d = b_zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                            {hi_d, lo_d} = fast_prod;
                            done_d       = 1'b1;
`else
                            state_d  = S_CALC;
                            busy_d   = 1'b1;
                            cnt_d    = CNT_W'(XLEN);
                            is_div_d = 1'b0;
                            neg_d    = rs_s ^ rt_s;
                            rs_neg_d = rs_s;
                            b_zero_d = (rt_val == '0);
                            rs_cap_d = rs_val;
                            opb_d    = abs_rs;
                            acc_d    = {{XLEN{1'b0}}, abs_rt};
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = S_CALC;
                            busy_d   = 1'b1;
                            cnt_d    = CNT_W'(XLEN);
                            is_div_d = 1'b1;
                            neg_d    = rs_s ^ rt_s;
                            rs_neg_d = rs_s;
                            b_zero_d = (rt_val == '0);
                            rs_cap_d = rs_val;
                            opb_d    = abs_rt;
                            acc_d    = {{XLEN{1'b0}}, abs_rs};
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                // acc holds {remainder, quotient} for divide, {partial, multiplier} for multiply.
                if (is_div_q) begin
                    if (!div_trial[XLEN])
                        acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*XLEN-2:0], 1'b0};
                end else begin
                    if (acc_q[0])
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    else
                        acc_d = {1'b0, acc_q[2*XLEN-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (b_zero_q) begin
                    hi_d   = rs_cap_q;
                    lo_d   = '1;
                    div0_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything: drop the operation and leave HI/LO untouched.
        if (flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            div0_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            rs_cap_q <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rs_neg_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            rs_cap_q <= rs_cap_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rs_neg_q <= rs_neg_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
